imem_fetch_arbiter: RTL and testbench

Controller for the MIPS instruction memory. It first sequences a word-serial program load into the memory's write port. It then shares the memory's single combinational read port between two requesters: port 0 is the core's instruction fetch, and port 1 is an auxiliary reader such as a debug or constant-load path. Arbitration is round-robin, and read responses are registered.

---
 rtl/imem_fetch_arbiter.sv | 148 ++++++++++++++
 tb/tb_imem_fetch_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_arbiter.sv
// imem_fetch_arbiter
//   Front end for the MIPS instruction memory. After reset it streams a
//   program into the memory write port, one word per accepted beat, until all
//   N = 2**L words are written. It then shares the single combinational read
//   port between the instruction fetch (port 0) and an auxiliary reader
//   (port 1) using round-robin arbitration with registered responses.
//
// Ports
//   clk, rst                    clock; asynchronous active-low reset
//   load_valid/load_data        program word stream
//   load_ready                  word accepted this cycle (LOAD state)
//   load_done                   high while in RUN
//   reload                      one-cycle pulse, restarts the program load
//   reqX_valid/reqX_addr        read request, addr is byte address [31:2]
//   reqX_ready                  request granted this cycle
//   rspX_valid/rspX_data        registered read response, one cycle after grant
//   mem_we/mem_waddr/mem_wdata  memory write port
//   mem_raddr/mem_rdata         memory read port (rdata combinational)
module imem_fetch_arbiter #(
  parameter int W = 32,
  parameter int L = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_valid,
  input  logic [W-1:0] load_data,
  output logic         load_ready,
  output logic         load_done,
  input  logic         reload,
  input  logic         req0_valid,
  input  logic [29:0]  req0_addr,
  output logic         req0_ready,
  output logic         rsp0_valid,
  output logic [W-1:0] rsp0_data,
  input  logic         req1_valid,
  input  logic [29:0]  req1_addr,
  output logic         req1_ready,
  output logic         rsp1_valid,
  output logic [W-1:0] rsp1_data,
  output logic         mem_we,
  output logic [L-1:0] mem_waddr,
  output logic [W-1:0] mem_wdata,
  output logic [L-1:0] mem_raddr,
  input  logic [W-1:0] mem_rdata
);

  localparam int       N         = 1 << L;
  localparam logic [L:0] WCNT_LAST = (L+1)'(N - 1);

  typedef enum logic {
    S_LOAD = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t       state, state_nxt;
  logic [L:0]   wcnt, wcnt_nxt;
  logic         last_grant, last_grant_nxt;
  logic         gnt0, gnt1;
  logic         load_accept;

  // Upper address bits are deliberately ignored so read indices wrap modulo N.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{req0_addr[29:L], req1_addr[29:L]};

  always_comb begin
    state_nxt      = state;
    wcnt_nxt       = wcnt;
    last_grant_nxt = last_grant;
    gnt0           = 1'b0;
    gnt1           = 1'b0;
    load_accept    = 1'b0;
    case (state)
      S_LOAD: begin
        load_accept = load_valid;
        if (load_valid) begin
          wcnt_nxt = wcnt + 1'b1;
        end
        // Reload restarts the count even if a word lands this cycle; that word
        // is still written at the old index.
        if (reload) begin
          wcnt_nxt = '0;
        end else if (load_valid && (wcnt == WCNT_LAST)) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (reload) begin
          // Reload beats any request: no grant in this cycle.
          state_nxt = S_LOAD;
          wcnt_nxt  = '0;
        end else begin
          // last_grant = 1 means port 1 was served last, so port 0 wins a tie.
          if (req0_valid && (!req1_valid || last_grant)) begin
            gnt0 = 1'b1;
          end else if (req1_valid) begin
            gnt1 = 1'b1;
          end
          if (gnt0) last_grant_nxt = 1'b0;
          if (gnt1) last_grant_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = S_LOAD;
      end
    endcase
  end

  assign load_ready = (state == S_LOAD);
  assign load_done  = (state == S_RUN);
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  // The write port is gated by reset so it reads idle while rst is held low,
  // even if a load word is being presented.
  assign mem_we    = load_accept & rst;
  assign mem_waddr = mem_we ? wcnt[L-1:0] : '0;
  assign mem_wdata = mem_we ? load_data : '0;
  assign mem_raddr = gnt0 ? req0_addr[L-1:0] :
                     gnt1 ? req1_addr[L-1:0] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_LOAD;
      wcnt       <= '0;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nxt;
      wcnt       <= wcnt_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  // Stage p0 -> p1: capture read data for the granted port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_data  <= '0;
      rsp1_data  <= '0;
    end else begin
      rsp0_valid <= gnt0;
      rsp1_valid <= gnt1;
      if (gnt0) rsp0_data <= mem_rdata;
      if (gnt1) rsp1_data <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
module tb_imem_fetch_arbiter;

  localparam int W = 32;
  localparam int L = 6;
  localparam int N = 1 << L;

  logic         clk = 1'b0;
  logic         rst;
  logic         load_valid;
  logic [W-1:0] load_data;
  logic         load_ready, load_done;
  logic         reload;
  logic         req0_valid, req1_valid;
  logic [29:0]  req0_addr, req1_addr;
  logic         req0_ready, req1_ready;
  logic         rsp0_valid, rsp1_valid;
  logic [W-1:0] rsp0_data, rsp1_data;
  logic         mem_we;
  logic [L-1:0] mem_waddr, mem_raddr;
  logic [W-1:0] mem_wdata, mem_rdata;

  logic [W-1:0] mem [N];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  imem_fetch_arbiter #(.W(W), .L(L)) dut (
    .clk       (clk),
    .rst       (rst),
    .load_valid(load_valid),
    .load_data (load_data),
    .load_ready(load_ready),
    .load_done (load_done),
    .reload    (reload),
    .req0_valid(req0_valid),
    .req0_addr (req0_addr),
    .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid),
    .rsp0_data (rsp0_data),
    .req1_valid(req1_valid),
    .req1_addr (req1_addr),
    .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid),
    .rsp1_data (rsp1_data),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata)
  );

  // Memory model: synchronous write, combinational read, never cleared.
  always @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end
  assign mem_rdata = mem[mem_raddr];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".load_ready"}, load_ready, 1);
    chk({tag, ".load_done"},  load_done,  0);
    chk({tag, ".req0_ready"}, req0_ready, 0);
    chk({tag, ".req1_ready"}, req1_ready, 0);
    chk({tag, ".rsp0_valid"}, rsp0_valid, 0);
    chk({tag, ".rsp1_valid"}, rsp1_valid, 0);
    chk({tag, ".rsp0_data"},  rsp0_data,  0);
    chk({tag, ".rsp1_data"},  rsp1_data,  0);
    chk({tag, ".mem_we"},     mem_we,     0);
    chk({tag, ".mem_waddr"},  mem_waddr,  0);
    chk({tag, ".mem_wdata"},  mem_wdata,  0);
    chk({tag, ".mem_raddr"},  mem_raddr,  0);
  endtask

  // Stream n words base+i. Starts and ends at a negedge (+1).
  task automatic load_words(input logic [W-1:0] base, input int n,
                            input bit chk_wr, input bit chk_stall);
    bit stalled_ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      load_valid = 1'b1;
      load_data  = base + W'(i);
      #1;
      if (chk_wr) begin
        chk("load.mem_we",     mem_we,     1);
        chk("load.mem_waddr",  mem_waddr,  64'(i));
        chk("load.mem_wdata",  mem_wdata,  64'(base + W'(i)));
        chk("load.load_ready", load_ready, 1);
        chk("load.load_done",  load_done,  0);
      end
      if (req0_ready || req1_ready) stalled_ok = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    load_valid = 1'b0;
    #1;
    if (chk_stall) chk("reload.req_stalled", stalled_ok, 1);
    if (n == N) begin
      chk("load.done_rises",  load_done,  1);
      chk("load.ready_falls", load_ready, 0);
    end
  endtask

  initial begin
    rst        = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    reload     = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_addr  = '0;
    req1_addr  = '0;
    for (int i = 0; i < N; i++) mem[i] = '0;

    // Reset state
    @(negedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;

    // Program load
    load_words(32'h1000_0000, N, 1'b1, 1'b0);

    // Contention from a fresh load: port 0 wins the first tie, then alternate
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      req0_valid = 1'b1; req0_addr = 30'd3;
      req1_valid = 1'b1; req1_addr = 30'd9;
      #1;
      chk("cont.req0_ready", req0_ready, 64'((k % 2) == 0));
      chk("cont.req1_ready", req1_ready, 64'((k % 2) == 1));
      chk("cont.mem_raddr",  mem_raddr,  ((k % 2) == 0) ? 64'd3 : 64'd9);
      @(posedge clk);
      #1;
      chk("cont.rsp0_valid", rsp0_valid, 64'((k % 2) == 0));
      chk("cont.rsp1_valid", rsp1_valid, 64'((k % 2) == 1));
      if ((k % 2) == 0) chk("cont.rsp0_data", rsp0_data, 64'h1000_0003);
      else              chk("cont.rsp1_data", rsp1_data, 64'h1000_0009);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    chk("idle.mem_raddr", mem_raddr, 0);
    @(posedge clk);
    #1;
    chk("idle.rsp0_valid", rsp0_valid, 0);
    chk("idle.rsp0_hold",  rsp0_data,  64'h1000_0003);
    chk("idle.rsp1_hold",  rsp1_data,  64'h1000_0009);

    // Single port
    @(negedge clk);
    req0_valid = 1'b1; req0_addr = 30'd5;
    #1;
    chk("single.req0_ready", req0_ready, 1);
    chk("single.req1_ready", req1_ready, 0);
    chk("single.mem_raddr",  mem_raddr,  5);
    @(posedge clk);
    #1;
    chk("single.rsp0_valid", rsp0_valid, 1);
    chk("single.rsp0_data",  rsp0_data,  64'h1000_0005);
    chk("single.rsp1_valid", rsp1_valid, 0);
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    @(posedge clk);
    #1;
    chk("single.one_cycle", rsp0_valid, 0);

    // Index wrap on port 1
    @(negedge clk);
    req1_valid = 1'b1; req1_addr = 30'h47;
    #1;
    chk("wrap.req1_ready", req1_ready, 1);
    chk("wrap.mem_raddr",  mem_raddr,  7);
    @(posedge clk);
    #1;
    chk("wrap.rsp1_valid", rsp1_valid, 1);
    chk("wrap.rsp1_data",  rsp1_data,  64'h1000_0007);
    @(negedge clk);
    req1_valid = 1'b0;

    // Reload beats a simultaneous request; request stalls through the load
    @(negedge clk);
    reload = 1'b1;
    req0_valid = 1'b1; req0_addr = 30'd5;
    #1;
    chk("reload.req0_ready", req0_ready, 0);
    chk("reload.mem_raddr",  mem_raddr,  0);
    @(posedge clk);
    #1;
    chk("reload.rsp0_valid", rsp0_valid, 0);
    chk("reload.load_done",  load_done,  0);
    chk("reload.load_ready", load_ready, 1);
    @(negedge clk);
    reload = 1'b0;
    #1;
    chk("reload.stall0", req0_ready, 0);
    load_words(32'h2000_0000, N, 1'b0, 1'b1);
    chk("reload.req0_served", req0_ready, 1);
    chk("reload.mem_raddr",   mem_raddr,  5);
    @(posedge clk);
    #1;
    chk("reload.rsp0_valid2", rsp0_valid, 1);
    chk("reload.rsp0_data",   rsp0_data,  64'h2000_0005);
    @(negedge clk);
    req0_valid = 1'b0;

    // Asynchronous reset mid-load
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    load_words(32'h3000_0000, 10, 1'b0, 1'b0);
    @(negedge clk);
    load_valid = 1'b1;
    load_data  = 32'h3000_000A;
    #1;
    chk("midload.mem_waddr", mem_waddr, 10);
    #2;
    rst = 1'b0;
    #1;
    chk_reset_outputs("midload_rst");
    @(negedge clk);
    load_valid = 1'b0;
    rst = 1'b1;
    load_words(32'h1000_0000, N, 1'b1, 1'b0);

    // Asynchronous reset with a granted read in flight
    @(negedge clk);
    req1_valid = 1'b1; req1_addr = 30'd9;
    #1;
    chk("midread.req1_ready", req1_ready, 1);
    #1;
    rst = 1'b0;
    #1;
    chk("midread.req1_ready_rst", req1_ready, 0);
    chk("midread.mem_raddr",      mem_raddr,  0);
    chk("midread.load_done",      load_done,  0);
    chk("midread.load_ready",     load_ready, 1);
    @(posedge clk);
    #1;
    chk("midread.rsp1_valid", rsp1_valid, 0);
    chk("midread.rsp1_data",  rsp1_data,  0);
    @(negedge clk);
    req1_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midread.after_release", load_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
